// File: rtl/agu_cfg_pkg.sv
// Shared types for the AGU configuration queue: job record layout,
// launcher FSM states and small mode/reset helpers.
package agu_cfg_pkg;

    localparam int CFG_IDX_W  = 8;
    localparam int CFG_TRIP_W = 8;
    localparam int CFG_LIM_W  = 6;

    // mode[MODE_FC_BIT] selects an FC job; the other mode bit is carried but not decoded
    localparam int MODE_FC_BIT = 0;

    // One queued job: raw command fields plus the limits derived at push time
    typedef struct packed {
        logic [1:0]            mode;
        logic [CFG_IDX_W-1:0]  idx_cnt;
        logic [CFG_TRIP_W-1:0] trip_cnt;
        logic                  is_new;
        logic                  pad_u;
        logic                  pad_l;
        logic [CFG_LIM_W-1:0]  lim_r;
        logic [CFG_LIM_W-1:0]  lim_d;
        logic [CFG_LIM_W-1:0]  row_cnt;
    } agu_cfg_t;

    localparam int CFG_W = $bits(agu_cfg_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } agu_state_e;

    function automatic logic is_fc_mode(input logic [1:0] mode);
        return mode[MODE_FC_BIT];
    endfunction

    // Value of the active configuration after reset: everything zero except is_new
    function automatic agu_cfg_t cfg_reset_value();
        agu_cfg_t c;
        c        = '0;
        c.is_new = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/agu_cfg_queue_cfg_fifo.sv
// Small synchronous FIFO of packed job records with flush.
// Read data is the head entry, visible combinationally so the consumer
// can load it on the same edge that pops it.
module cfg_fifo
    import agu_cfg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CFG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_acc;
    logic             pop_acc;
    logic [W-1:0]     entry_vec [DEPTH];

    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    assign rd_data = entry_vec[rd_ptr_q];

    // Pointer and occupancy update; flush wins over any push and clears the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_acc);
        count_d  = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [W-1:0] entry_q, entry_d;

            // Entry is written only by an accepted push addressed to it
            always_comb begin
                entry_d = entry_q;
                if (push_acc && !flush && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = push_data;
                end
            end

            // Entry storage; contents are don't-care while not counted, so no reset
            always_ff @(posedge clk) begin
                entry_q <= entry_d;
            end

            assign entry_vec[gi] = entry_q;
        end
    endgenerate

endmodule

// File: rtl/agu_cfg_queue.sv
// AGU configuration front-end: derives padding limits and row count for
// each accepted command, queues jobs, and launches them one at a time
// into the AGU with a single-cycle start pulse.
module agu_cfg_queue
    import agu_cfg_pkg::*;
#(
    parameter int IDX_W  = CFG_IDX_W,
    parameter int TRIP_W = CFG_TRIP_W,
    parameter int LIM_W  = CFG_LIM_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [IDX_W-1:0]         cmd_idx_cnt,
    input  logic [TRIP_W-1:0]        cmd_trip_cnt,
    input  logic                     cmd_is_new,
    input  logic [3:0]               cmd_pad_code,
    input  logic                     cmd_cut_y,
    input  logic                     flush,
    input  logic                     agu_done,
    output logic [1:0]               conf_mode,
    output logic [IDX_W-1:0]         conf_idx_cnt,
    output logic [TRIP_W-1:0]        conf_trip_cnt,
    output logic                     conf_is_new,
    output logic                     conf_pad_u,
    output logic                     conf_pad_l,
    output logic [LIM_W-1:0]         conf_lim_r,
    output logic [LIM_W-1:0]         conf_lim_d,
    output logic [LIM_W-1:0]         conf_row_cnt,
    output logic                     start_conv,
    output logic                     start_fc,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_level
);

    // The queued record layout is fixed by the package widths; the width
    // parameters here exist so the ports read naturally and must keep their defaults.
    localparam int RW = TRIP_W + 1;
    localparam logic [LIM_W-1:0] LIM_MAX = '1;

    // pad_code is {R, L, D, U}
    logic pad_u, pad_d, pad_l, pad_r;
    assign pad_u = cmd_pad_code[0];
    assign pad_d = cmd_pad_code[1];
    assign pad_l = cmd_pad_code[2];
    assign pad_r = cmd_pad_code[3];

    logic [1:0]       d_sub;
    logic [1:0]       r_sub;
    logic [RW-1:0]    r_base;
    logic [RW-1:0]    r_val;
    logic [RW-1:0]    row_full;
    logic [LIM_W-1:0] lim_d_val;
    logic [LIM_W-1:0] lim_r_sat;
    logic [LIM_W-1:0] row_sat;
    agu_cfg_t         push_cfg;

    // Derive limits at push time so the launch path is just a register load
    always_comb begin
        // lim_d: at most three subtrahends of one, so 3 - d_sub never underflows
        d_sub     = {1'b0, pad_u} + {1'b0, pad_d} + {1'b0, cmd_cut_y};
        lim_d_val = LIM_W'(2'd3 - d_sub);

        // lim_r: trip + 1 - L - R in TRIP_W+1 bits, floored at zero, then saturated
        r_sub     = {1'b0, pad_l} + {1'b0, pad_r};
        r_base    = {1'b0, cmd_trip_cnt} + RW'(1);
        r_val     = (r_base < RW'(r_sub)) ? '0 : (r_base - RW'(r_sub));
        lim_r_sat = (r_val > RW'(LIM_MAX)) ? LIM_MAX : r_val[LIM_W-1:0];

        // row_cnt: ceil(trip / 2) == (trip + 1) >> 1, then saturated
        row_full  = r_base >> 1;
        row_sat   = (row_full > RW'(LIM_MAX)) ? LIM_MAX : row_full[LIM_W-1:0];

        push_cfg          = '0;
        push_cfg.mode     = cmd_mode;
        push_cfg.idx_cnt  = cmd_idx_cnt;
        push_cfg.trip_cnt = cmd_trip_cnt;
        push_cfg.is_new   = cmd_is_new;
        push_cfg.pad_u    = pad_u;
        push_cfg.pad_l    = pad_l;
        push_cfg.lim_r    = lim_r_sat;
        push_cfg.lim_d    = lim_d_val;
        push_cfg.row_cnt  = row_sat;
    end

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CFG_W-1:0] fifo_rd_data;
    agu_cfg_t         head_cfg;

    // Ready depends only on registered fullness, so a pop never frees a slot in the same cycle
    assign cmd_ready = ~fifo_full & ~rst;
    assign head_cfg  = fifo_rd_data;

    cfg_fifo #(
        .DEPTH (DEPTH),
        .W     (CFG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid & cmd_ready),
        .push_data (push_cfg),
        .pop       (fifo_pop),
        .flush     (flush),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (q_level)
    );

    agu_state_e state_q, state_d;
    agu_cfg_t   conf_q, conf_d;
    logic       start_conv_q, start_conv_d;
    logic       start_fc_q, start_fc_d;

    // Launcher next-state: pop from IDLE, or from RUN when the AGU reports done
    always_comb begin
        state_d      = state_q;
        conf_d       = conf_q;
        start_conv_d = 1'b0;
        start_fc_d   = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fifo_pop = ~fifo_empty;
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (agu_done) begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fifo_pop) begin
            state_d      = ST_LAUNCH;
            conf_d       = head_cfg;
            start_fc_d   = is_fc_mode(head_cfg.mode);
            start_conv_d = ~is_fc_mode(head_cfg.mode);
        end
    end

    // Launcher state, active configuration and start pulses are all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            conf_q       <= cfg_reset_value();
            start_conv_q <= 1'b0;
            start_fc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            conf_q       <= conf_d;
            start_conv_q <= start_conv_d;
            start_fc_q   <= start_fc_d;
        end
    end

    assign conf_mode     = conf_q.mode;
    assign conf_idx_cnt  = conf_q.idx_cnt;
    assign conf_trip_cnt = conf_q.trip_cnt;
    assign conf_is_new   = conf_q.is_new;
    assign conf_pad_u    = conf_q.pad_u;
    assign conf_pad_l    = conf_q.pad_l;
    assign conf_lim_r    = conf_q.lim_r;
    assign conf_lim_d    = conf_q.lim_d;
    assign conf_row_cnt  = conf_q.row_cnt;
    assign start_conv    = start_conv_q;
    assign start_fc      = start_fc_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
